// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK bank excitation sequencer.
//   - jk_state_e : controller state encoding (INIT, IDLE, ERR)
//   - jk_exc_t   : per-bit excitation code, packed as {j, k}
//   - next_count : modulo up/down step used by the sequencer
package jk_seq_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    ERR  = 2'd2
  } jk_state_e;

  typedef logic [1:0] jk_exc_t;

  localparam jk_exc_t EXC_HOLD = 2'b00;  // j=0 k=0
  localparam jk_exc_t EXC_CLR  = 2'b01;  // j=0 k=1
  localparam jk_exc_t EXC_SET  = 2'b10;  // j=1 k=0
  localparam jk_exc_t EXC_TGL  = 2'b11;  // j=1 k=1

  // One modulo-mod step from p in the requested direction.
  function automatic int unsigned next_count(input int unsigned p,
                                             input logic        up,
                                             input int unsigned mod);
    if (up) begin
      return (p == mod - 32'd1) ? 32'd0 : p + 32'd1;
    end
    return (p == 32'd0) ? mod - 32'd1 : p - 32'd1;
  endfunction

endpackage

// File: rtl/jk_excite_seq_exc.sv
// Combinational J/K excitation for a bank moving from cur to nxt.
// Unchanged bits get hold (0/0). Changing bits get set/clear, or toggle (1/1)
// when JK_TOGGLE_EXC_EN is defined.
// Ports:
//   cur  in  WIDTH  value the bank will hold before the edge
//   nxt  in  WIDTH  value the bank must hold after the edge
//   j_c  out WIDTH  J inputs (combinational)
//   k_c  out WIDTH  K inputs (combinational)
module jk_excite
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j_c,
  output logic [WIDTH-1:0] k_c
);

  jk_exc_t exc [WIDTH];

  // Per-bit excitation code, then split into the J and K vectors.
  always_comb begin
    j_c = '0;
    k_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      exc[i] = EXC_HOLD;
`ifdef JK_TOGGLE_EXC_EN
      if (cur[i] != nxt[i]) exc[i] = EXC_TGL;
`else
      if (cur[i] != nxt[i]) exc[i] = nxt[i] ? EXC_SET : EXC_CLR;
`endif
      j_c[i] = exc[i][1];
      k_c[i] = exc[i][0];
    end
  end

endmodule

// File: rtl/jk_excite_seq.sv
// Driver for an external bank of posedge JK flip-flops. Produces registered
// J/K so the bank follows a modulo-MOD up/down count or a loaded value, and
// compares the bank's Q read-back against the expected value (sticky err).
// Optional macro: JK_TOGGLE_EXC_EN (toggle excitation, see jk_excite).
// Ports:
//   clk, rst        clock (shared with the bank), async active-high reset
//   load_valid/ready/val  load handshake; ready only in IDLE
//   en, up          count enable and direction (1 = up)
//   q_fb            bank Q read-back
//   j, k            registered bank excitation
//   tc              registered terminal-count pulse
//   chk_vld         q_fb is being checked
//   err             sticky divergence flag
module jk_excite_seq
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             chk_vld,
  output logic             err
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 32'd1);

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             tc_q, tc_d;
  logic             chk_vld_q, chk_vld_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] nxt_c;
  logic             wrap_c;
  logic [WIDTH-1:0] exc_j_c, exc_k_c;

  assign load_ready = (state_q == IDLE);

  // Next planned value: load (saturated) beats count beats hold.
  always_comb begin
    nxt_c  = p_q;
    wrap_c = 1'b0;
    if (load_valid && load_ready) begin
      nxt_c = (32'(load_val) >= MOD) ? CNT_MAX : load_val;
    end else if (en) begin
      nxt_c  = WIDTH'(next_count(32'(p_q), up, MOD));
      wrap_c = up ? (p_q == CNT_MAX) : (p_q == '0);
    end
  end

  jk_excite #(.WIDTH(WIDTH)) u_exc (
    .cur (p_q),
    .nxt (nxt_c),
    .j_c (exc_j_c),
    .k_c (exc_k_c)
  );

  // Controller: INIT releases the clear, IDLE steps and checks, ERR holds.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    c_d       = c_q;
    j_d       = '0;
    k_d       = '0;
    tc_d      = 1'b0;
    chk_vld_d = chk_vld_q;
    err_d     = err_q;
    unique case (state_q)
      INIT: begin
        c_d       = '0;
        chk_vld_d = 1'b1;
        state_d   = IDLE;
      end
      IDLE: begin
        if (chk_vld_q && (q_fb != c_q)) begin
          state_d   = ERR;
          err_d     = 1'b1;
          chk_vld_d = 1'b0;
        end else begin
          j_d  = exc_j_c;
          k_d  = exc_k_c;
          tc_d = wrap_c;
          p_d  = nxt_c;
          c_d  = p_q;
        end
      end
      ERR: begin
        chk_vld_d = 1'b0;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Reset drives a clear command (j=0, k=1s) straight onto the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      p_q       <= '0;
      c_q       <= '0;
      j_q       <= '0;
      k_q       <= '1;
      tc_q      <= 1'b0;
      chk_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      c_q       <= c_d;
      j_q       <= j_d;
      k_q       <= k_d;
      tc_q      <= tc_d;
      chk_vld_q <= chk_vld_d;
      err_q     <= err_d;
    end
  end

  assign j       = j_q;
  assign k       = k_q;
  assign tc      = tc_q;
  assign chk_vld = chk_vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: behavioural JK bank, cycle model, directed vectors.
module tb_jk_excite_seq;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_val;
  logic         en;
  logic         up;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         tc;
  logic         chk_vld;
  logic         err;

  logic [W-1:0] fault;
  logic [W-1:0] bank_q = 4'b1011;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_excite_seq #(.WIDTH(W), .MOD(MOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_val   (load_val),
    .en         (en),
    .up         (up),
    .q_fb       (q_fb),
    .j          (j),
    .k          (k),
    .tc         (tc),
    .chk_vld    (chk_vld),
    .err        (err)
  );

  // Behavioural bank of posedge JK flip-flops; fault corrupts the read-back only.
  always @(posedge clk) begin
    for (int i = 0; i < int'(W); i++) begin
      case ({j[i], k[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end
  assign q_fb = bank_q ^ fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PH_INIT = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_ERR  = 2;

  int           m_phase;
  logic [W-1:0] m_cnt;   // value commanded for the next edge
  logic [W-1:0] m_bank;  // value the bank must hold now
  logic [W-1:0] e_j, e_k;
  logic         e_tc, e_chk, e_err;

  function automatic logic [W-1:0] mdl_next(input logic [W-1:0] cur, input logic lv,
                                            input logic [W-1:0] lval, input logic e,
                                            input logic u);
    if (lv) return (32'(lval) >= MOD) ? W'(MOD - 1) : lval;
    if (!e) return cur;
    return u ? W'((32'(cur) + 1) % MOD) : W'((32'(cur) + MOD - 1) % MOD);
  endfunction

  function automatic logic mdl_wrap(input logic [W-1:0] cur, input logic lv,
                                    input logic [W-1:0] lval, input logic e, input logic u);
    logic [W-1:0] nv;
    nv = mdl_next(cur, lv, lval, e, u);
    return e && !lv && (u ? (nv < cur) : (nv > cur));
  endfunction

  // Returns {j, k} needed to move the bank from a to b.
  function automatic logic [2*W-1:0] mdl_exc(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef JK_TOGGLE_EXC_EN
    return {a ^ b, a ^ b};
`else
    return {~a & b, a & ~b};
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= PH_INIT;
      m_cnt   <= '0;
      m_bank  <= '0;
      e_j     <= '0;
      e_k     <= '1;
      e_tc    <= 1'b0;
      e_chk   <= 1'b0;
      e_err   <= 1'b0;
    end else begin
      e_tc <= 1'b0;
      case (m_phase)
        PH_INIT: begin
          m_phase <= PH_RUN;
          e_j     <= '0;
          e_k     <= '0;
          e_chk   <= 1'b1;
        end
        PH_RUN: begin
          if (q_fb != m_bank) begin
            m_phase <= PH_ERR;
            e_err   <= 1'b1;
            e_chk   <= 1'b0;
            e_j     <= '0;
            e_k     <= '0;
          end else begin
            {e_j, e_k} <= mdl_exc(m_cnt, mdl_next(m_cnt, load_valid, load_val, en, up));
            e_tc       <= mdl_wrap(m_cnt, load_valid, load_val, en, up);
            m_bank     <= m_cnt;
            m_cnt      <= mdl_next(m_cnt, load_valid, load_val, en, up);
          end
        end
        default: begin
          e_j <= '0;
          e_k <= '0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_j",     32'(j),          32'(e_j));
    chk("m_k",     32'(k),          32'(e_k));
    chk("m_tc",    32'(tc),         32'(e_tc));
    chk("m_chk",   32'(chk_vld),    32'(e_chk));
    chk("m_err",   32'(err),        32'(e_err));
    chk("m_ready", 32'(load_ready), 32'(m_phase == PH_RUN));
    if (m_phase == PH_RUN) chk("m_bank", 32'(bank_q), 32'(m_bank));
  end

  // ---------------- directed stimulus ----------------
`ifdef JK_TOGGLE_EXC_EN
  localparam logic [W-1:0] J78 = 4'b1111;
  localparam logic [W-1:0] K78 = 4'b1111;
`else
  localparam logic [W-1:0] J78 = 4'b1000;
  localparam logic [W-1:0] K78 = 4'b0111;
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  // Async reset asserted mid-cycle, held across one edge, then the INIT edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_rst_k"}, 32'(k), 32'hF);
    chk({tag, "_rst_j"}, 32'(j), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_init_q"},   32'(q_fb),    32'h0);
    chk({tag, "_init_chk"}, 32'(chk_vld), 32'h1);
    chk({tag, "_init_err"}, 32'(err),     32'h0);
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_val = '0; en = 1'b0; up = 1'b1; fault = '0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    chk("init_q",   32'(q_fb),       32'h0);
    chk("init_chk", 32'(chk_vld),    32'h1);
    chk("init_err", 32'(err),        32'h0);
    chk("init_rdy", 32'(load_ready), 32'h1);

    // Up count for 12 edges: bank shows 0,1..9,0,1 then 2 after the hold edge.
    en = 1'b1; up = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("up_q",  32'(q_fb), 32'((e - 1) % 10));
      chk("up_tc", 32'(tc),   32'(e == 10));
      if (e == 8) begin
        chk("jk78_j", 32'(j), 32'(J78));
        chk("jk78_k", 32'(k), 32'(K78));
      end
    end
    en = 1'b0;
    tick();
    chk("up_end_q", 32'(q_fb), 32'h2);

    // Down: 2 -> 1 -> 0 -> 9 (wrap).
    en = 1'b1; up = 1'b0;
    tick(); tick();
    chk("dn_tc0", 32'(tc), 32'h0);
    tick();
    chk("dn_tc_wrap", 32'(tc), 32'h1);
    en = 1'b0;
    tick();
    chk("dn_q9", 32'(q_fb), 32'h9);
    chk("dn_tc_off", 32'(tc), 32'h0);

    // Load beats count: from 9, load 5 with en/up high (no wrap, no increment).
    load_valid = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
    tick();
    chk("ld5_tc", 32'(tc), 32'h0);
    load_valid = 1'b0; en = 1'b0;
    tick();
    chk("ld5_q", 32'(q_fb), 32'h5);

    // Out-of-range load saturates to MOD-1.
    load_valid = 1'b1; load_val = 4'd13; en = 1'b1; up = 1'b0;
    tick();
    load_valid = 1'b0; en = 1'b0;
    tick();
    chk("ld13_q", 32'(q_fb), 32'h9);

    // Corrupt read-back bit 2 for one cycle.
    fault = 4'b0100;
    tick();
    fault = '0;
    chk("flt_err", 32'(err),        32'h1);
    chk("flt_j",   32'(j),          32'h0);
    chk("flt_k",   32'(k),          32'h0);
    chk("flt_rdy", 32'(load_ready), 32'h0);
    chk("flt_chk", 32'(chk_vld),    32'h0);
    en = 1'b1; up = 1'b1; load_valid = 1'b1; load_val = 4'd3;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("err_sticky", 32'(err),        32'h1);
      chk("err_hold_q", 32'(q_fb),       32'h9);
      chk("err_rdy",    32'(load_ready), 32'h0);
    end
    load_valid = 1'b0; en = 1'b0;

    pulse_reset("rec");

    // Count to p = 6 (bank 5), then reset mid-count.
    en = 1'b1; up = 1'b1;
    for (int e = 0; e < 6; e++) tick();
    chk("pre_mid_q", 32'(q_fb), 32'h5);
    pulse_reset("mid");

    // Counting resumes from 0.
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("resume_q", 32'(q_fb), 32'(e - 1));
    end
    en = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/jk_excite_seq.md
Name: jk_excite_seq

Overview:
- Driver end of a JK flip-flop bank. Generates registered J/K excitation so that an external WIDTH-bit bank of posedge JK flip-flops follows a modulo-MOD up/down count or a loaded value.
- Reads the bank's Q outputs back and flags any divergence from the expected sequence.
- Sits between lab control logic (load/enable/direction) and discrete JK flip-flop instances.

Parameters:
- WIDTH, 4, bit width of the driven JK bank.
- MOD, 10, count modulus. Legal range 2..2^WIDTH; count runs 0..MOD-1.

Ports:
- clk  in  1  single clock, posedge; shared with the JK bank.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  high when a load can be accepted.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- q_fb  in  WIDTH  Q outputs of the external bank.
- j  out  WIDTH  J inputs of the bank (registered).
- k  out  WIDTH  K inputs of the bank (registered).
- tc  out  1  terminal-count pulse (registered).
- chk_vld  out  1  high when q_fb is being checked.
- err  out  1  sticky mismatch flag.

Behaviour:
- Internal registers:
  - p: plan; the value the bank will hold after the next edge.
  - c: check; the value the bank holds now.
  - state: one of INIT, IDLE, ERR.
- Reset (asynchronous) values:
  - j = 0 and k = all ones, a clear command to the bank.
  - p = 0, c = 0, chk_vld = 0, err = 0, tc = 0, load_ready = 0, state = INIT.
- INIT:
  - First edge after reset release: the bank clears.
  - j <= 0, k <= 0, c <= 0, chk_vld <= 1, state <= IDLE.
- IDLE, at each edge, choose nxt in this priority order:
  - load_valid & load_ready: nxt = load_val, saturated to MOD-1 if load_val >= MOD. Load has priority over en.
  - en & up: nxt = (p == MOD-1) ? 0 : p+1. tc <= 1 on wrap.
  - en & ~up: nxt = (p == 0) ? MOD-1 : p-1. tc <= 1 on wrap.
  - Otherwise nxt = p.
- At the same edge, for each bit i:
  - Bit rising 0->1: j = 1, k = 0.
  - Bit falling 1->0: j = 0, k = 1.
  - Bit unchanged: j = 0, k = 0.
- Register updates at that edge: j/k <= excitation(p -> nxt), p <= nxt, c <= p.
- tc is a 1-cycle pulse. It is 0 on any cycle without a wrap.
- load_ready = 1 in IDLE only, combinational from state.
- Latency:
  - Inputs sampled at edge E produce j/k at E.
  - The bank reflects the new value after E+1.
  - That value is visible on c/q_fb compare after E+1.
  - Full rate: one step per cycle, no bubbles.
- Check:
  - While chk_vld = 1 and state = IDLE, q_fb != c at any edge -> state <= ERR and err <= 1.
- ERR:
  - j = k = 0 (bank holds), load_ready = 0, chk_vld = 0, tc = 0.
  - Exits only via rst.
- rst mid-count: the asynchronous clear immediately asserts k = all ones. The sequence restarts from INIT.

Optional Feature:
- JK_TOGGLE_EXC_EN defined:
  - Any changing bit is driven j = k = 1 (toggle), in both directions. Unchanged bits remain 0/0.
  - The INIT clear is unchanged.
- JK_TOGGLE_EXC_EN undefined: the exclusive J/K excitation above.
- Bank Q sequence, tc and err behaviour are identical in both builds.

Decomposition:
- Package jk_seq_pkg holds:
  - the state encoding constants (INIT, IDLE, ERR);
  - the excitation encoding constants;
  - a function next_count(p, up, MOD).
- Sub-module jk_excite: a combinational per-bank mapping of (cur, nxt) -> (j, k). It contains the JK_TOGGLE_EXC_EN selection. The top level instantiates it once.

Test Plan:
- Reset with a behavioural JK bank preset to 4'b1011 -> first edge gives q_fb = 0, chk_vld = 1, err = 0.
- Up count: en = 1, up = 1 for 12 cycles -> q_fb runs 1..9, 0, 1, 2; tc pulses one cycle after the 9 -> 0 step is commanded; j/k on the 7 -> 8 step = j 4'b1000, k 4'b0111 (toggle build: j = k = 4'b1111).
- Down wrap from 0: en = 1, up = 0 at p = 0 -> q_fb = 9, tc pulse.
- Load with en high in the same cycle: load_val = 5 -> q_fb = 5, not an increment. load_val = 13 -> saturates, q_fb = 9.
- Fault injection: force q_fb bit 2 for one cycle -> err = 1 on the next edge, j = k = 0 thereafter, load_ready = 0 until rst.
- Assert rst mid-count at p = 6 -> k = 4'b1111 immediately, bank returns to 0, normal counting resumes.
